// File: rtl/riscv_multicycle_core.sv
// Multi-cycle RV32I core: FETCH/DECODE/EXEC/MEM/WB sequencing with stallable
// instruction and data ports, sticky halt/trap status and a retire trace.
module riscv_multicycle_core #(
  parameter logic [31:0] RESET_PC     = 32'h0000_0000,
  parameter int          NUM_REGS     = 32,
  parameter bit          HALT_ON_ZERO = 1'b1,
  parameter int          CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  input  logic             imem_ready,
  input  logic [31:0]      imem_rdata,
  output logic             dmem_req,
  output logic             dmem_we,
  output logic [31:0]      dmem_addr,
  output logic [3:0]       dmem_be,
  output logic [31:0]      dmem_wdata,
  input  logic             dmem_ready,
  input  logic [31:0]      dmem_rdata,
  output logic             retire,
  output logic [31:0]      retire_pc,
  output logic [31:0]      retire_instr,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic             trap,
  output logic [2:0]       dbg_state
);

  // Handshake: a request is raised and held with stable address/data until the
  // cycle in which ready is seen high; that rising edge completes the transfer.

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT, S_TRAP
  } state_t;

  localparam int RIDX_W = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  state_t      state, next_state;
  logic [31:0] pc, ir, a, b, res, npc;
  logic [31:0] rf [0:NUM_REGS-1];

  logic [6:0]  opcode, f7;
  logic [4:0]  rd, rs1, rs2;
  logic [2:0]  f3;
  assign opcode = ir[6:0];
  assign rd     = ir[11:7];
  assign f3     = ir[14:12];
  assign rs1    = ir[19:15];
  assign rs2    = ir[24:20];
  assign f7     = ir[31:25];

  // Decode is purely combinational from IR, which is stable from DECODE to WB.
  logic        legal, is_halt, uses_rd, uses_rs1, uses_rs2, bad_reg;
  logic [31:0] imm;
  always_comb begin
    legal    = 1'b0;
    is_halt  = 1'b0;
    uses_rd  = 1'b0;
    uses_rs1 = 1'b0;
    uses_rs2 = 1'b0;
    imm      = '0;
    case (opcode)
      OP_LUI, OP_AUIPC: begin
        legal = 1'b1; uses_rd = 1'b1; imm = {ir[31:12], 12'b0};
      end
      OP_JAL: begin
        legal = 1'b1; uses_rd = 1'b1;
        imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
      end
      OP_JALR: begin
        legal = (f3 == 3'b000); uses_rd = 1'b1; uses_rs1 = 1'b1;
        imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_BRANCH: begin
        legal = (f3 != 3'b010) && (f3 != 3'b011); uses_rs1 = 1'b1; uses_rs2 = 1'b1;
        imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
      end
      OP_LOAD: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
        uses_rd = 1'b1; uses_rs1 = 1'b1; imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_STORE: begin
        legal = f3 inside {3'b000, 3'b001, 3'b010};
        uses_rs1 = 1'b1; uses_rs2 = 1'b1; imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
      end
      OP_IMM: begin
        if (f3 == 3'b001)      legal = (f7 == 7'b0000000);
        else if (f3 == 3'b101) legal = (f7 == 7'b0000000) || (f7 == 7'b0100000);
        else                   legal = 1'b1;
        uses_rd = 1'b1; uses_rs1 = 1'b1; imm = {{20{ir[31]}}, ir[31:20]};
      end
      OP_REG: begin
        legal = (f7 == 7'b0000000) ||
                ((f7 == 7'b0100000) && ((f3 == 3'b000) || (f3 == 3'b101)));
        uses_rd = 1'b1; uses_rs1 = 1'b1; uses_rs2 = 1'b1;
      end
      OP_FENCE:  legal = (f3 == 3'b000);
      OP_SYSTEM: begin
        is_halt = (ir == 32'h0000_0073) || (ir == 32'h0010_0073);
        legal   = is_halt;
      end
      default: begin
        is_halt = HALT_ON_ZERO && (ir == 32'h0);
        legal   = is_halt;
      end
    endcase
  end

  assign bad_reg = (uses_rd  && (int'(rd)  >= NUM_REGS)) ||
                   (uses_rs1 && (int'(rs1) >= NUM_REGS)) ||
                   (uses_rs2 && (int'(rs2) >= NUM_REGS));

  logic [31:0] rs1_val, rs2_val;
  assign rs1_val = (rs1 == 5'd0) ? 32'h0 : rf[rs1[RIDX_W-1:0]];
  assign rs2_val = (rs2 == 5'd0) ? 32'h0 : rf[rs2[RIDX_W-1:0]];

  logic [31:0] alu_b, alu_y;
  logic        taken;
  always_comb begin
    alu_b = (opcode == OP_REG) ? b : imm;
    alu_y = '0;
    case (f3)
      3'b000: alu_y = ((opcode == OP_REG) && f7[5]) ? a - alu_b : a + alu_b;
      3'b001: alu_y = a << alu_b[4:0];
      3'b010: alu_y = {31'b0, $signed(a) < $signed(alu_b)};
      3'b011: alu_y = {31'b0, a < alu_b};
      3'b100: alu_y = a ^ alu_b;
      3'b101: alu_y = f7[5] ? 32'($signed(a) >>> alu_b[4:0]) : a >> alu_b[4:0];
      3'b110: alu_y = a | alu_b;
      default: alu_y = a & alu_b;
    endcase
    case (f3)
      3'b000:  taken = (a == b);
      3'b001:  taken = (a != b);
      3'b100:  taken = $signed(a) < $signed(b);
      3'b101:  taken = !($signed(a) < $signed(b));
      3'b110:  taken = a < b;
      3'b111:  taken = !(a < b);
      default: taken = 1'b0;
    endcase
  end

  // EXEC results: res carries the writeback value or the effective address.
  logic [31:0] pc4, ea, ex_res, ex_npc;
  logic        ex_mem, ex_trap, mis_mem;
  assign pc4 = pc + 32'd4;
  assign ea  = a + imm;
  always_comb begin
    ex_res  = '0;
    ex_npc  = pc4;
    ex_mem  = 1'b0;
    mis_mem = 1'b0;
    case (opcode)
      OP_LUI:    ex_res = imm;
      OP_AUIPC:  ex_res = pc + imm;
      OP_JAL:    begin ex_res = pc4; ex_npc = pc + imm; end
      OP_JALR:   begin ex_res = pc4; ex_npc = ea & ~32'd1; end
      OP_BRANCH: ex_npc = taken ? pc + imm : pc4;
      OP_LOAD, OP_STORE: begin
        ex_res  = ea;
        ex_mem  = 1'b1;
        mis_mem = ((f3[1:0] == 2'b01) && ea[0]) || ((f3[1:0] == 2'b10) && (ea[1:0] != 2'b00));
      end
      OP_IMM, OP_REG: ex_res = alu_y;
      default: ex_res = '0;
    endcase
    ex_trap = mis_mem || (ex_npc[1:0] != 2'b00);
  end

  logic        is_store;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_val;
  assign is_store = (opcode == OP_STORE);
  assign ld_byte  = dmem_rdata[{res[1:0], 3'b000} +: 8];
  assign ld_half  = res[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
  always_comb begin
    case (f3)
      3'b000:  ld_val = {{24{ld_byte[7]}}, ld_byte};
      3'b001:  ld_val = {{16{ld_half[15]}}, ld_half};
      3'b100:  ld_val = {24'b0, ld_byte};
      3'b101:  ld_val = {16'b0, ld_half};
      default: ld_val = dmem_rdata;
    endcase
  end

  logic do_retire;
  always_comb begin
    next_state = state;
    imem_req   = 1'b0;
    dmem_req   = 1'b0;
    dmem_we    = 1'b0;
    dmem_be    = 4'b0000;
    dmem_wdata = '0;
    do_retire  = 1'b0;
    case (state)
      S_FETCH: begin
        imem_req = 1'b1;
        if (imem_ready) next_state = S_DECODE;
      end
      S_DECODE: next_state = (!legal || bad_reg) ? S_TRAP : S_EXEC;
      S_EXEC:   next_state = ex_trap ? S_TRAP : (ex_mem ? S_MEM : S_WB);
      S_MEM: begin
        dmem_req = 1'b1;
        dmem_we  = is_store;
        case (f3[1:0])
          2'b00:   begin dmem_be = 4'b0001 << res[1:0]; dmem_wdata = {4{b[7:0]}};  end
          2'b01:   begin dmem_be = 4'b0011 << res[1:0]; dmem_wdata = {2{b[15:0]}}; end
          default: begin dmem_be = 4'b1111;             dmem_wdata = b;            end
        endcase
        if (dmem_ready) begin
          next_state = is_store ? S_FETCH : S_WB;
          do_retire  = is_store;
        end
      end
      S_WB: begin
        next_state = is_halt ? S_HALT : S_FETCH;
        do_retire  = 1'b1;
      end
      default: next_state = state;
    endcase
    // A request must not be visible while reset is held.
    if (!rst_n) begin
      imem_req = 1'b0;
      dmem_req = 1'b0;
    end
  end

  assign imem_addr = pc;
  assign dmem_addr = {res[31:2], 2'b00};
  assign dbg_state = state;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state        <= S_FETCH;
      pc           <= RESET_PC;
      ir           <= '0;
      a            <= '0;
      b            <= '0;
      res          <= '0;
      npc          <= '0;
      retire       <= 1'b0;
      retire_pc    <= '0;
      retire_instr <= '0;
      instret      <= '0;
      halted       <= 1'b0;
      trap         <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
    end else begin
      state  <= next_state;
      retire <= do_retire;
      case (state)
        S_FETCH:  if (imem_ready) ir <= imem_rdata;
        S_DECODE: begin a <= rs1_val; b <= rs2_val; end
        S_EXEC:   begin res <= ex_res; npc <= ex_npc; end
        S_MEM: begin
          if (dmem_ready && is_store) pc <= pc4;
          if (dmem_ready && !is_store) res <= ld_val;
        end
        S_WB: begin
          if (uses_rd && (rd != 5'd0)) rf[rd[RIDX_W-1:0]] <= res;
          if (is_halt) halted <= 1'b1;
          else         pc <= npc;
        end
        default: ;
      endcase
      if (do_retire) begin
        retire_pc    <= pc;
        retire_instr <= ir;
        instret      <= instret + CNT_W'(1);
      end
      if ((state != S_TRAP) && (next_state == S_TRAP)) trap <= 1'b1;
    end
  end

endmodule

// File: tb/tb_riscv_multicycle_core.sv
// Directed bench for riscv_multicycle_core: small programs run from a bench
// memory model, with hand-computed register, lane, timing and status checks.
module tb_riscv_multicycle_core;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        imem_req, imem_ready;
  logic [31:0] imem_addr, imem_rdata;
  logic        dmem_req, dmem_we, dmem_ready;
  logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
  logic [3:0]  dmem_be;
  logic        retire, halted, trap;
  logic [31:0] retire_pc, retire_instr, instret;
  logic [2:0]  dbg_state;

  riscv_multicycle_core dut (
    .clk(clk), .rst_n(rst_n),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_ready(imem_ready), .imem_rdata(imem_rdata),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_be(dmem_be),
    .dmem_wdata(dmem_wdata), .dmem_ready(dmem_ready), .dmem_rdata(dmem_rdata),
    .retire(retire), .retire_pc(retire_pc), .retire_instr(retire_instr), .instret(instret),
    .halted(halted), .trap(trap), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset ----------------
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // ---------------- memory model ----------------
  logic [31:0] imem [0:63];
  logic [31:0] dmem [0:63];
  logic [31:0] stall_addr = 32'hFFFF_FFFF;
  int          istall_n = 0, dstall_n = 0;
  int          icnt = 0, dcnt = 0;
  logic        mon_clr = 1'b1;
  int          cyc = 0;

  always_comb begin
    imem_rdata = imem[imem_addr[7:2]];
    dmem_rdata = dmem[dmem_addr[7:2]];
    imem_ready = imem_req && (icnt >= ((imem_addr == stall_addr) ? istall_n : 0));
    dmem_ready = dmem_req && (dcnt >= (dmem_we ? 0 : dstall_n));
  end

  always @(posedge clk) begin
    if (!imem_req) icnt <= 0; else if (!imem_ready) icnt <= icnt + 1;
    if (!dmem_req) dcnt <= 0; else if (!dmem_ready) dcnt <= dcnt + 1;
    if (mon_clr) cyc <= 0; else cyc <= cyc + 1;
  end

  // ---------------- monitor ----------------
  logic [31:0] ret_cyc_q[$], ret_pc_q[$], fetch_q[$], be_q[$], wd_q[$];
  int          dreq_cycles, istall_seen, dstall_seen;

  always @(negedge clk) begin
    if (mon_clr) begin
      ret_cyc_q.delete(); ret_pc_q.delete(); fetch_q.delete(); be_q.delete(); wd_q.delete();
      dreq_cycles = 0; istall_seen = 0; dstall_seen = 0;
    end else begin
      if (retire) begin
        ret_cyc_q.push_back(32'(cyc));
        ret_pc_q.push_back(retire_pc);
      end
      if (imem_req && imem_ready)  fetch_q.push_back(imem_addr);
      if (imem_req && !imem_ready) istall_seen++;
      if (dmem_req) begin
        dreq_cycles++;
        if (!dmem_ready) dstall_seen++;
        else begin
          be_q.push_back({28'b0, dmem_be});
          if (dmem_we) begin
            wd_q.push_back(dmem_wdata);
            for (int k = 0; k < 4; k++)
              if (dmem_be[k]) dmem[dmem_addr[7:2]][8*k +: 8] = dmem_wdata[8*k +: 8];
          end
        end
      end
    end
  end

  // ---------------- scoreboard ----------------
  logic [31:0] exp_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // which: 0 retire cycles, 1 retire pcs, 2 fetch addresses, 3 byte enables, 4 store data
  task automatic check_q(input string tag, input int which);
    logic [31:0] obs;
    int          n;
    case (which)
      0: n = ret_cyc_q.size();
      1: n = ret_pc_q.size();
      2: n = fetch_q.size();
      3: n = be_q.size();
      default: n = wd_q.size();
    endcase
    check({tag, "_count"}, 32'(n), 32'(exp_q.size()));
    for (int i = 0; i < n && i < exp_q.size(); i++) begin
      case (which)
        0: obs = ret_cyc_q[i];
        1: obs = ret_pc_q[i];
        2: obs = fetch_q[i];
        3: obs = be_q[i];
        default: obs = wd_q[i];
      endcase
      check($sformatf("%s[%0d]", tag, i), obs, exp_q[i]);
    end
    exp_q.delete();
  endtask

  // ---------------- driver tasks ----------------
  function automatic logic [31:0] i_t(int imm, int rs1, int f3, int rd, logic [6:0] op);
    return {imm[11:0], rs1[4:0], f3[2:0], rd[4:0], op};
  endfunction
  function automatic logic [31:0] s_t(int imm, int rs2, int rs1, int f3);
    return {imm[11:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:0], 7'b0100011};
  endfunction
  function automatic logic [31:0] b_t(int imm, int rs2, int rs1, int f3);
    return {imm[12], imm[10:5], rs2[4:0], rs1[4:0], f3[2:0], imm[4:1], imm[11], 7'b1100011};
  endfunction
  function automatic logic [31:0] j_t(int imm, int rd);
    return {imm[20], imm[10:1], imm[11], imm[19:12], rd[4:0], 7'b1101111};
  endfunction

  localparam logic [6:0] OPI = 7'b0010011, LD = 7'b0000011, JR = 7'b1100111;
  localparam logic [31:0] ECALL = 32'h0000_0073;

  task automatic hold_reset();
    rst_n = 1'b0;
    mon_clr = 1'b1;
    repeat (2) @(posedge clk);
  endtask

  task automatic release_reset();
    #1;
    rst_n = 1'b1;
    mon_clr = 1'b0;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'h0000_007F;
  endtask

  task automatic run_until_stop(input string tag, input int max_cycles);
    int i;
    for (i = 0; i < max_cycles; i++) begin
      @(posedge clk); #1;
      if (halted || trap) break;
    end
    check({tag, "_stopped"}, {31'b0, halted | trap}, 32'd1);
    @(negedge clk); #1;
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    clear_imem();

    // reset state
    hold_reset();
    #1;
    check("rst_imem_req", {31'b0, imem_req}, 32'd0);
    check("rst_dmem_req", {31'b0, dmem_req}, 32'd0);
    check("rst_retire", {31'b0, retire}, 32'd0);
    check("rst_instret", instret, 32'd0);
    check("rst_status", {30'b0, halted, trap}, 32'd0);
    check("rst_retire_pc", retire_pc, 32'd0);

    // ADDI/ADDI/ECALL with zero-wait fetch
    clear_imem();
    imem[0] = i_t(5, 0, 0, 1, OPI);
    imem[1] = i_t(-7, 1, 0, 2, OPI);
    imem[2] = ECALL;
    hold_reset(); release_reset();
    run_until_stop("t1", 100);
    check("t1_x2", dut.rf[2], 32'hFFFF_FFFE);
    check("t1_x1", dut.rf[1], 32'd5);
    check("t1_halted", {31'b0, halted}, 32'd1);
    check("t1_trap", {31'b0, trap}, 32'd0);
    check("t1_instret", instret, 32'd3);
    check("t1_retire_instr", retire_instr, ECALL);
    exp_q = '{32'd4, 32'd8, 32'd12};
    check_q("t1_retire_cycle", 0);
    repeat (3) @(posedge clk); #1;
    check("t1_no_req_after_halt", {30'b0, imem_req, dmem_req}, 32'd0);

    // store/load lanes
    clear_imem();
    imem[0] = i_t(-2, 0, 0, 2, OPI);
    imem[1] = s_t(8, 2, 0, 2);
    imem[2] = i_t(9, 0, 0, 3, LD);
    imem[3] = i_t(9, 0, 4, 4, LD);
    imem[4] = s_t(6, 2, 0, 1);
    imem[5] = s_t(7, 2, 0, 0);
    imem[6] = ECALL;
    hold_reset(); release_reset();
    run_until_stop("t2", 200);
    check("t2_lb_x3", dut.rf[3], 32'hFFFF_FFFF);
    check("t2_lbu_x4", dut.rf[4], 32'h0000_00FF);
    exp_q = '{32'hF, 32'h2, 32'h2, 32'hC, 32'h8};
    check_q("t2_be", 3);
    exp_q = '{32'hFFFF_FFFE, 32'hFFFE_FFFE, 32'hFEFE_FEFE};
    check_q("t2_wdata", 4);
    exp_q = '{32'd4, 32'd8, 32'd13, 32'd18, 32'd22, 32'd26, 32'd30};
    check_q("t2_retire_cycle", 0);

    // BNE loop: three taken branches back to 0x8
    clear_imem();
    imem[0] = i_t(3, 0, 0, 1, OPI);
    imem[1] = j_t(8, 0);
    imem[2] = i_t(-1, 1, 0, 1, OPI);
    imem[3] = b_t(-4, 0, 1, 1);
    imem[4] = ECALL;
    hold_reset(); release_reset();
    run_until_stop("t3", 300);
    check("t3_x1", dut.rf[1], 32'd0);
    check("t3_instret", instret, 32'd10);
    check("t3_final_pc", retire_pc, 32'h10);
    exp_q = '{32'h0, 32'h4, 32'hC, 32'h8, 32'hC, 32'h8, 32'hC, 32'h8, 32'hC, 32'h10};
    check_q("t3_retire_pc", 1);

    // JAL / JALR
    clear_imem();
    imem[0] = j_t(16, 0);
    imem[4] = j_t(12, 1);
    imem[7] = i_t(0, 1, 0, 0, JR);
    imem[5] = ECALL;
    hold_reset(); release_reset();
    run_until_stop("t4", 200);
    check("t4_x1", dut.rf[1], 32'h14);
    exp_q = '{32'h0, 32'h10, 32'h1C, 32'h14};
    check_q("t4_fetch_addr", 2);

    // stalled fetch (5) and stalled load (3)
    clear_imem();
    imem[0] = i_t(32'h123, 0, 0, 6, OPI);
    imem[1] = s_t(16, 6, 0, 2);
    imem[2] = i_t(16, 0, 2, 7, LD);
    imem[3] = ECALL;
    stall_addr = 32'h0; istall_n = 5; dstall_n = 3;
    hold_reset(); release_reset();
    run_until_stop("t5", 200);
    check("t5_x7", dut.rf[7], 32'h123);
    check("t5_imem_stall_cycles", 32'(istall_seen), 32'd5);
    check("t5_dmem_stall_cycles", 32'(dstall_seen), 32'd3);
    exp_q = '{32'd9, 32'd13, 32'd21, 32'd25};
    check_q("t5_retire_cycle", 0);
    stall_addr = 32'hFFFF_FFFF; istall_n = 0; dstall_n = 0;

    // misaligned LW traps with no data request
    clear_imem();
    imem[0] = i_t(32'h55, 0, 0, 8, OPI);
    imem[1] = i_t(6, 0, 2, 8, LD);
    hold_reset(); release_reset();
    run_until_stop("t6", 100);
    check("t6_trap", {31'b0, trap}, 32'd1);
    check("t6_halted", {31'b0, halted}, 32'd0);
    check("t6_dmem_req_cycles", 32'(dreq_cycles), 32'd0);
    check("t6_x8_kept", dut.rf[8], 32'h55);
    check("t6_instret", instret, 32'd1);
    check("t6_pc_frozen", dut.pc, 32'h4);

    // undefined opcode 0x7F
    clear_imem();
    hold_reset(); release_reset();
    run_until_stop("t7", 50);
    check("t7_trap", {31'b0, trap}, 32'd1);
    check("t7_instret", instret, 32'd0);
    check("t7_retires", 32'(ret_pc_q.size()), 32'd0);

    // zero word halts and retires once
    clear_imem();
    imem[0] = 32'h0;
    hold_reset(); release_reset();
    run_until_stop("t8", 50);
    check("t8_halted", {31'b0, halted}, 32'd1);
    check("t8_trap", {31'b0, trap}, 32'd0);
    check("t8_instret", instret, 32'd1);

    // reset asserted in the middle of a stalled fetch
    clear_imem();
    imem[0] = i_t(1, 0, 0, 1, OPI);
    stall_addr = 32'h4; istall_n = 1000;
    hold_reset(); release_reset();
    repeat (10) @(posedge clk); #1;
    check("t9_pre_imem_req", {31'b0, imem_req}, 32'd1);
    check("t9_pre_instret", instret, 32'd1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("t9_imem_req", {31'b0, imem_req}, 32'd0);
    check("t9_pc", dut.pc, 32'h0);
    check("t9_instret", instret, 32'd0);
    check("t9_retire_pc", retire_pc, 32'd0);
    check("t9_retire_instr", retire_instr, 32'd0);
    check("t9_x1", dut.rf[1], 32'd0);
    stall_addr = 32'hFFFF_FFFF; istall_n = 0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
